mem_port_arbiter: RTL

- Shares one physical memory port between the pipeline's instruction-fetch port (I) and data-memory port (D).
- Sits between the cpu datapath's i_mem_*/d_mem_* interfaces and the single pmem_* interface.
- Latches the winning request and runs exactly one word transaction to completion, then returns a one-cycle registered response to the winner.
- D has priority; a starvation counter guarantees I forward progress.

---
 rtl/mem_port_arbiter.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one physical memory port between the instruction-fetch (I) and data (D) clients.
// D has priority; a saturating starvation counter forces an I grant after STARVE_MAX D wins.
module mem_port_arbiter #(
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic             clk,
    input  logic             reset,

    input  logic             i_mem_read,
    input  logic             i_mem_write,
    input  logic [WIDTH-1:0] i_mem_address,
    input  logic [WIDTH-1:0] i_mem_wdata,
    input  logic [1:0]       i_mem_byte_enable,
    output logic             i_mem_resp,
    output logic [WIDTH-1:0] i_mem_rdata,

    input  logic             d_mem_read,
    input  logic             d_mem_write,
    input  logic [WIDTH-1:0] d_mem_address,
    input  logic [WIDTH-1:0] d_mem_wdata,
    input  logic [1:0]       d_mem_byte_enable,
    output logic             d_mem_resp,
    output logic [WIDTH-1:0] d_mem_rdata,

    output logic             pmem_read,
    output logic             pmem_write,
    output logic [WIDTH-1:0] pmem_address,
    output logic [WIDTH-1:0] pmem_wdata,
    output logic [1:0]       pmem_byte_enable,
    input  logic             pmem_resp,
    input  logic [WIDTH-1:0] pmem_rdata
);

    typedef enum logic [1:0] {
        StIdle,
        StIBusy,
        StDBusy,
        StDone
    } state_e;

    localparam logic [3:0] StarveMax = 4'(STARVE_MAX);

    state_e           state_q, state_d;
    logic [3:0]       starve_q, starve_d;
    logic [WIDTH-1:0] addr_q, addr_d;
    logic [WIDTH-1:0] wdata_q, wdata_d;
    logic [1:0]       be_q, be_d;
    logic             wr_q, wr_d;
    logic             own_d_q, own_d_d;
    logic [WIDTH-1:0] i_rdata_q, i_rdata_d;
    logic [WIDTH-1:0] d_rdata_q, d_rdata_d;

    logic i_req;
    logic d_req;
    logic d_wins;
    logic busy;

    assign i_req  = i_mem_read | i_mem_write;
    assign d_req  = d_mem_read | d_mem_write;
    assign d_wins = d_req && (!i_req || (starve_q < StarveMax));

    always_comb begin
        state_d   = state_q;
        starve_d  = starve_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        be_d      = be_q;
        wr_d      = wr_q;
        own_d_d   = own_d_q;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;

        unique case (state_q)
            StIdle: begin
                if (d_wins) begin
                    addr_d  = d_mem_address;
                    wdata_d = d_mem_wdata;
                    be_d    = d_mem_byte_enable;
                    wr_d    = d_mem_write;
                    own_d_d = 1'b1;
                    state_d = StDBusy;
                    if (i_req) begin
                        starve_d = (starve_q == 4'hF) ? 4'hF : starve_q + 4'd1;
                    end else begin
                        starve_d = 4'd0;
                    end
                end else if (i_req) begin
                    addr_d   = i_mem_address;
                    wdata_d  = i_mem_wdata;
                    be_d     = i_mem_byte_enable;
                    wr_d     = i_mem_write;
                    own_d_d  = 1'b0;
                    starve_d = 4'd0;
                    state_d  = StIBusy;
                end
            end
            StIBusy, StDBusy: begin
                // Writes capture too; the client treats that value as don't-care.
                if (pmem_resp) begin
                    if (own_d_q) begin
                        d_rdata_d = pmem_rdata;
                    end else begin
                        i_rdata_d = pmem_rdata;
                    end
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            starve_q  <= 4'd0;
            addr_q    <= '0;
            wdata_q   <= '0;
            be_q      <= 2'b00;
            wr_q      <= 1'b0;
            own_d_q   <= 1'b0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            starve_q  <= starve_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            be_q      <= be_d;
            wr_q      <= wr_d;
            own_d_q   <= own_d_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
        end
    end

    assign busy = (state_q == StIBusy) || (state_q == StDBusy);

    assign pmem_read        = busy & ~wr_q;
    assign pmem_write       = busy & wr_q;
    assign pmem_address     = addr_q;
    assign pmem_wdata       = wdata_q;
    assign pmem_byte_enable = be_q;

    assign i_mem_resp  = (state_q == StDone) && !own_d_q;
    assign d_mem_resp  = (state_q == StDone) && own_d_q;
    assign i_mem_rdata = i_rdata_q;
    assign d_mem_rdata = d_rdata_q;

endmodule
